// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: turns a raw, bouncing push-button into clean one-cycle
// enable strobes for the pulse-enabled Gray counter. The chain is a
// synchronizer, then a debounce filter, then a press/hold/auto-repeat FSM.
module btn_pulse_gen #(
  parameter int DB_CYCLES      = 500000,
  parameter int HOLD_CYCLES    = 25000000,
  parameter int REPEAT_CYCLES  = 5000000,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic pulse,
  output logic btn_level,
  output logic held
);

  localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  logic           btn_in;
  logic           sync1, sync2;
  logic [DBW-1:0] db_cnt;
  logic [TW-1:0]  tmr;
  state_t         state;

  // Polarity is fixed before the synchronizer so everything downstream is active-high.
  assign btn_in = btn_raw ^ BTN_ACTIVE_LOW;

  // Two-flop synchronizer; resets to the released state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (sync2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= ~btn_level;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press/hold/repeat FSM with registered pulse and held outputs.
  // Release is tested first in every state so it always beats a timer expiry,
  // and held lingers one cycle past the exit from REPEAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      held  <= (state == S_REPEAT);
      case (state)
        S_IDLE: begin
          if (btn_level) begin
            pulse <= 1'b1;
            tmr   <= '0;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!btn_level) begin
            state <= S_IDLE;
          end else if (repeat_en && tmr == HOLD_LAST) begin
            pulse <= 1'b1;
            held  <= 1'b1;
            tmr   <= '0;
            state <= S_REPEAT;
          end else if (tmr != HOLD_LAST) begin
            // Saturate so a late repeat_en fires on the very next cycle.
            tmr <= tmr + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!btn_level) begin
            state <= S_IDLE;
          end else if (!repeat_en) begin
            tmr   <= '0;
            state <= S_HOLD;
          end else if (tmr == REP_LAST) begin
            pulse <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
